// File: rtl/imem_loader_if.sv
// Signal bundle between a program-byte source and the instruction-memory loader.
// The master drives the load request and byte stream; the slave (the loader) drives everything else.
interface imem_loader_if;
    logic        start;
    logic [15:0] word_count;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        core_reset_n;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, word_count, byte_data, byte_valid,
        input  byte_ready, mem_write_enable, mem_write_address, mem_write_data,
        input  core_reset_n, busy, done, error
    );

    modport slave (
        input  start, word_count, byte_data, byte_valid,
        output byte_ready, mem_write_enable, mem_write_address, mem_write_data,
        output core_reset_n, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Streams little-endian program bytes into 32-bit instruction-memory writes and
// holds the core in reset until a complete program has been written.
module imem_loader #(
    parameter int WORDS          = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    imem_loader_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        FINISH
    } state_t;

    state_t         state, state_next;
    logic [15:0]    word_count_q;
    logic [15:0]    word_idx;
    logic [1:0]     byte_cnt;
    logic [TW-1:0]  timeout_cnt;
    logic [31:0]    word_q;
    logic           error_q;
    logic           core_reset_q;

    logic count_ok;
    logic start_ok;
    logic start_bad;
    logic xfer;
    logic timeout_hit;
    logic last_word;

    logic byte_ready;
    logic mem_write_enable;
    logic busy;
    logic done;

    assign count_ok    = (bus.word_count != 16'd0) && ({16'd0, bus.word_count} <= 32'(WORDS));
    assign start_ok    = (state == IDLE) && bus.start && count_ok;
    assign start_bad   = (state == IDLE) && bus.start && !count_ok;
    assign xfer        = (state == RECV) && bus.byte_valid;
    assign timeout_hit = (state == RECV) && !bus.byte_valid &&
                         (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_word   = (word_idx + 16'd1) == word_count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        byte_ready       = 1'b0;
        mem_write_enable = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (timeout_hit)                    state_next = IDLE;
                else if (xfer && byte_cnt == 2'd3)  state_next = WRITE;
            end
            WRITE: begin
                mem_write_enable = 1'b1;
                busy             = 1'b1;
                state_next       = last_word ? FINISH : RECV;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count_q <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            timeout_cnt  <= '0;
            word_q       <= '0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        word_count_q <= bus.word_count;
                        word_idx     <= '0;
                        byte_cnt     <= '0;
                        timeout_cnt  <= '0;
                        word_q       <= '0;
                        error_q      <= 1'b0;
                        core_reset_q <= 1'b0;
                    end else if (start_bad) begin
                        error_q <= 1'b1;
                    end
                end
                RECV: begin
                    if (xfer) begin
                        // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
                        word_q      <= {bus.byte_data, word_q[31:8]};
                        byte_cnt    <= byte_cnt + 2'd1;
                        timeout_cnt <= '0;
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    if (last_word) core_reset_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready        = byte_ready;
    assign bus.mem_write_enable  = mem_write_enable;
    assign bus.mem_write_address = {14'd0, word_idx, 2'b00};
    assign bus.mem_write_data    = word_q;
    assign bus.core_reset_n      = core_reset_q;
    assign bus.busy              = busy;
    assign bus.done              = done;
    assign bus.error             = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-validation table, directed corner
// sequences and randomized loads checked against a byte-list-to-word model.
module tb_imem_loader;

    localparam int WORDS = 64;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(.WORDS(WORDS), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] wc;
        logic        exp_err;
        logic        exp_busy;
    } start_vec_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    wr_t  wr_q[$];
    wr_t  mon_w;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   core_hi_writes = 0;
    logic core_at_done = 1'b0;
    logic exp_core = 1'b0;
    logic [7:0] bytes_in [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_write_enable) begin
            mon_w.addr = bus.mem_write_address;
            mon_w.data = bus.mem_write_data;
            wr_q.push_back(mon_w);
            if (bus.core_reset_n) core_hi_writes++;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            core_at_done = bus.core_reset_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.word_count = 16'd0;
        bus.byte_data  = 8'd0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        exp_core = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] wc);
        bus.start      = 1'b1;
        bus.word_count = wc;
        tick();
        bus.start      = 1'b0;
        bus.word_count = 16'($urandom);
    endtask

    // Holds byte_valid until the loader takes the byte; acc = cycle of acceptance.
    task automatic send_byte(input logic [7:0] b, output int acc);
        bit got = 1'b0;
        acc = -1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 16; k++) begin
            if (bus.byte_ready) begin
                acc = cyc;
                got = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.byte_valid = 1'b0;
        check("byte_accepted", 32'(got), 32'd1);
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps.
    task automatic run_load(input int cnt, input int mode, input bit inject, input string tag);
        int acc = 0;
        int gap;
        logic [31:0] exp_data;
        wr_q.delete();
        done_cnt = 0;
        core_hi_writes = 0;
        pulse_start(16'(cnt));
        for (int i = 0; i < 4 * cnt; i++) begin
            if (inject && i == 2) begin
                bus.start      = 1'b1;
                bus.word_count = 16'd1;
                tick();
                bus.start      = 1'b0;
            end
            gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (gap) tick();
            send_byte(bytes_in[i], acc);
        end
        for (int k = 0; k < 8 && done_cnt == 0; k++) tick();
        @(negedge clk);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < wr_q.size(); i++) begin
            exp_data = {bytes_in[4*i+3], bytes_in[4*i+2], bytes_in[4*i+1], bytes_in[4*i]};
            check({tag, "_addr"}, wr_q[i].addr, 32'(4 * i));
            check({tag, "_data"}, wr_q[i].data, exp_data);
        end
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_latency"}, 32'(done_cyc), 32'(acc + 2));
        check({tag, "_core_at_done"}, 32'(core_at_done), 32'd1);
        check({tag, "_core_low_in_write"}, 32'(core_hi_writes), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_core_after"}, 32'(bus.core_reset_n), 32'd1);
        exp_core = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_we"}, 32'(bus.mem_write_enable), 32'd0);
        check({tag, "_addr"}, bus.mem_write_address, 32'd0);
        check({tag, "_data"}, bus.mem_write_data, 32'd0);
        check({tag, "_core"}, 32'(bus.core_reset_n), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_error"}, 32'(bus.error), 32'd0);
    endtask

    start_vec_t tbl [6];

    initial begin
        int acc;
        logic [15:0] bad_wc;

        tbl[0] = '{16'd0,     1'b1, 1'b0};
        tbl[1] = '{16'd65,    1'b1, 1'b0};
        tbl[2] = '{16'hFFFF,  1'b1, 1'b0};
        tbl[3] = '{16'd1,     1'b0, 1'b1};
        tbl[4] = '{16'd64,    1'b0, 1'b1};
        tbl[5] = '{16'd2,     1'b0, 1'b1};

        do_reset();
        @(negedge clk);
        check_reset_values("reset");

        // Start acceptance table, each applied right after reset release.
        foreach (tbl[i]) begin
            do_reset();
            wr_q.delete();
            pulse_start(tbl[i].wc);
            @(negedge clk);
            check("tbl_error", 32'(bus.error), 32'(tbl[i].exp_err));
            check("tbl_busy", 32'(bus.busy), 32'(tbl[i].exp_busy));
            check("tbl_byte_ready", 32'(bus.byte_ready), 32'(tbl[i].exp_busy));
            check("tbl_core", 32'(bus.core_reset_n), 32'd0);
            repeat (3) tick();
            check("tbl_no_write", 32'(wr_q.size()), 32'd0);
        end

        // Two-word program, bytes back-to-back.
        do_reset();
        bytes_in[0] = 8'h13; bytes_in[1] = 8'h00; bytes_in[2] = 8'h00; bytes_in[3] = 8'h00;
        bytes_in[4] = 8'hB3; bytes_in[5] = 8'h00; bytes_in[6] = 8'h00; bytes_in[7] = 8'h00;
        run_load(2, 0, 1'b0, "b2b");

        // One word with byte_valid toggling every other cycle.
        bytes_in[0] = 8'h93; bytes_in[1] = 8'h05; bytes_in[2] = 8'h10; bytes_in[3] = 8'h00;
        run_load(1, 1, 1'b0, "toggle");

        // Bad starts keep core_reset_n and state; the next valid start clears error.
        wr_q.delete();
        pulse_start(16'd0);
        @(negedge clk);
        check("bad0_error", 32'(bus.error), 32'd1);
        check("bad0_core", 32'(bus.core_reset_n), 32'd1);
        check("bad0_busy", 32'(bus.busy), 32'd0);
        tick();
        pulse_start(16'd65);
        @(negedge clk);
        check("bad65_error", 32'(bus.error), 32'd1);
        check("bad65_core", 32'(bus.core_reset_n), 32'd1);
        check("bad65_busy", 32'(bus.busy), 32'd0);
        check("bad_no_write", 32'(wr_q.size()), 32'd0);
        tick();
        pulse_start(16'd1);
        @(negedge clk);
        check("good_clears_error", 32'(bus.error), 32'd0);
        check("good_busy", 32'(bus.busy), 32'd1);
        check("good_core_low", 32'(bus.core_reset_n), 32'd0);

        // Start pulsed mid-load is ignored.
        do_reset();
        for (int i = 0; i < 8; i++) bytes_in[i] = 8'($urandom);
        run_load(2, 2, 1'b1, "restart");

        // Full-depth load reaches the last word address.
        for (int i = 0; i < 4 * WORDS; i++) bytes_in[i] = 8'($urandom);
        run_load(WORDS, 0, 1'b0, "full");

        // Timeout after 3 bytes.
        do_reset();
        wr_q.delete();
        pulse_start(16'd2);
        for (int i = 0; i < 3; i++) send_byte(8'(i + 1), acc);
        repeat (TO - 1) tick();
        @(negedge clk);
        check("to_busy_before", 32'(bus.busy), 32'd1);
        check("to_error_before", 32'(bus.error), 32'd0);
        tick();
        @(negedge clk);
        check("to_error", 32'(bus.error), 32'd1);
        check("to_busy", 32'(bus.busy), 32'd0);
        check("to_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("to_core", 32'(bus.core_reset_n), 32'd0);
        check("to_no_write", 32'(wr_q.size()), 32'd0);

        // Asynchronous reset mid-word, then a fresh load from address 0.
        do_reset();
        wr_q.delete();
        pulse_start(16'd4);
        send_byte(8'hAA, acc);
        send_byte(8'hBB, acc);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) tick();
        check("async_rst_no_write", 32'(wr_q.size()), 32'd0);
        for (int i = 0; i < 4; i++) bytes_in[i] = 8'($urandom);
        run_load(1, 0, 1'b0, "post_rst");

        // Reset landing in WRITE drops the pending write.
        do_reset();
        wr_q.delete();
        pulse_start(16'd2);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), acc);
        reset_n = 1'b0;
        #1;
        check("wr_rst_we", 32'(bus.mem_write_enable), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) tick();
        check("wr_rst_no_write", 32'(wr_q.size()), 32'd0);

        // Randomized loads interleaved with rejected starts.
        do_reset();
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                bad_wc = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(WORDS + 1, 65535));
                wr_q.delete();
                pulse_start(bad_wc);
                repeat (2) tick();
                @(negedge clk);
                check("rnd_bad_error", 32'(bus.error), 32'd1);
                check("rnd_bad_core", 32'(bus.core_reset_n), 32'(exp_core));
                check("rnd_bad_no_write", 32'(wr_q.size()), 32'd0);
                tick();
            end else begin
                int cnt = int'($urandom_range(1, 8));
                for (int i = 0; i < 4 * cnt; i++) bytes_in[i] = 8'($urandom);
                run_load(cnt, 2, 1'b0, "rnd");
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
